cordic_seq: RTL
===============

# cordic_seq

Sequential, parametrised CORDIC vectoring engine. It converts a signed Cartesian pair (x, y) into magnitude and angle using one micro-rotation per clock. It replaces the single-shot behavioural converter with synthesizable registered datapath, a true arctangent table, full four-quadrant coverage via 90° pre-rotation, and a start/busy/done handshake. It sits between the sample source and the polar-domain consumers in the emulator datapath.

## Interface
- IW, 12: input width, signed two's complement
- GW, 4: guard (fraction) bits appended below inputs
- ITER, 12: number of micro-rotations; legal range 4..IW+GW
- AW, 12: angle width; full circle = 2^AW counts, signed output
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- x_in  in  IW  signed x, captured on accepted start
- y_in  in  IW  signed y, captured on accepted start
- busy  out  1  high from cycle after accepted start until done cycle
- done  out  1  one-cycle pulse, results valid
- r  out  IW+GW+1  unsigned magnitude, CORDIC-gain scaled (K≈1.6468), 2^GW fraction
- t  out  AW  signed angle, 2^AW counts per turn (AW=12: 1024 = 90°)

## Operation
- Internal datapath: signed W = IW+GW+2 bits for x, y; signed AW-bit angle accumulator z; iteration counter ceil(log2(ITER)) bits.
- Capture: x = x_in<<GW, y = y_in<<GW (sign-extended to W), z = 0.
- FSM states: IDLE, PRE, ROT, FIN.
  - IDLE: start=1 → capture, go PRE. start=0 → stay.
  - PRE (1 cycle): if x<0 and y>=0: (x,y) ← (y, −x), z ← +2^(AW−2). If x<0 and y<0: (x,y) ← (−y, x), z ← −2^(AW−2). Else unchanged. Then i ← 0, go ROT.
  - ROT (ITER cycles): if y>=0: x ← x + (y>>>i), y ← y − (x>>>i), z ← z + A[i]; else x ← x − (y>>>i), y ← y + (x>>>i), z ← z − A[i]. Use old x, y on both sides. i==ITER−1 → go FIN.
  - FIN (1 cycle): r ← x[IW+GW:0], t ← z, done=1. Go IDLE.
- >>> is arithmetic shift (floor). z wraps modulo 2^AW. (−x, 0) yields t = −2^(AW−1).
- A[i] = round(atan(2^−i) · 2^AW / 2π), elaborated at compile time. For AW=12: 512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- No gain compensation. Consumers divide by K.
- (0,0) input: r=0, t = sum of ±A[i] pattern. This result is defined but meaningless; it is not an error.

## Timing
- Reset (async assert, sync release): state IDLE, busy=0, done=0, r=0, t=0, internal regs 0.
- Start sampled at edge E0 (busy=0): busy=1 after E0. done=1 and busy=0 during the cycle after edge E0+ITER+2. Latency ITER+2 cycles; ITER=12 → 14.
- start while busy=1: ignored, no queueing. x_in/y_in are don't-care after capture.
- FIN returns to IDLE, so start during the done cycle is accepted. Throughput is one result per ITER+2 cycles.
- r, t hold the last result until the next done; they change only on the FIN edge.
- rst_n low mid-computation: abort immediately. No done pulse, r/t cleared. First start after release behaves as from power-up.

## Test plan
- Reset: hold rst_n=0 with start=1 → busy=0, done=0, r=0, t=0. Release, start x=100, y=0 → done exactly 14 cycles later, r within ±12 of 2635, t within ±2 of 0.
- Quadrants (ITER=12): (1000,1000) → t≈512; (−1000,1000) → t≈1536; (−1000,−1000) → t≈−1536; (0,−500) → t≈−1024. Each t within ±2; r within ±12 of K·|v|·16.
- Extremes: (−2048,−2048) → no overflow, r≈76300±16, t≈−1536. (−2048,0) → t=−2048 (wrap), r≈53960±16.
- Handshake: pulse start 3 times while busy → single done, result from the first capture. Assert start during the done cycle with new data → second done exactly 14 cycles later.
- Abort: assert rst_n=0 at ROT i=5 → outputs clear asynchronously, no done. After release, a fresh start completes normally.
- Parametric: ITER=16, GW=6, AW=16 → done at 18 cycles. A[0]=8192; (1,1)·scale → t within ±4 of 8192. Compare random 10k vectors bit-exactly against a model of the same algorithm.

Source files
------------

// File: rtl/cordic_seq.sv
// rtl/cordic_seq.sv - sequential CORDIC vectoring engine, one micro-rotation per clock
module cordic_seq #(
  parameter int IW   = 12,
  parameter int GW   = 4,
  parameter int ITER = 12,
  parameter int AW   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [IW-1:0] x_in,
  input  logic signed [IW-1:0] y_in,
  output logic                 busy,
  output logic                 done,
  output logic [IW+GW:0]       r,
  output logic signed [AW-1:0] t
);

  localparam int W  = IW + GW + 2;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int TN = 1 << CW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_ROT  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic signed [AW-1:0] QTR = AW'(1) << (AW - 2);

  // atan(2^-i) scaled to 2^AW counts per turn, evaluated at elaboration only
  function automatic int atan_count(input int i);
    real a;
    real scale;
    case (i)
      0:  a = 0.7853981633974483;
      1:  a = 0.4636476090008061;
      2:  a = 0.24497866312686414;
      3:  a = 0.12435499454676144;
      4:  a = 0.06241880999595735;
      5:  a = 0.031239833430268277;
      6:  a = 0.015623728620476831;
      7:  a = 0.007812341060101111;
      8:  a = 0.0039062301319669718;
      9:  a = 0.0019531225164788188;
      10: a = 0.0009765621895593195;
      11: a = 0.0004882812111948983;
      12: a = 0.00024414062014936177;
      13: a = 0.00012207031189367021;
      14: a = 0.00006103515617420877;
      15: a = 0.000030517578115526096;
      default: a = 1.0 / (2.0 ** i);
    endcase
    scale = (2.0 ** AW) / 6.283185307179586;
    return $rtoi(a * scale + 0.5);
  endfunction

  logic [AW-1:0] atan_tab [TN];

  for (genvar g = 0; g < TN; g++) begin : g_atan
    assign atan_tab[g] = AW'(atan_count(g));
  end

  logic [1:0]          state_q, state_d;
  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [AW-1:0] z_q, z_d;
  logic [CW-1:0]       i_q, i_d;
  logic [IW+GW:0]      r_q, r_d;
  logic signed [AW-1:0] t_q, t_d;
  logic                done_q, done_d;

  logic signed [W-1:0]  x_sh, y_sh;
  logic signed [AW-1:0] a_cur;

  assign x_sh  = x_q >>> i_q;
  assign y_sh  = y_q >>> i_q;
  assign a_cur = atan_tab[i_q];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    r_d     = r_q;
    t_d     = t_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = {{(W-IW-GW){x_in[IW-1]}}, x_in, {GW{1'b0}}};
          y_d     = {{(W-IW-GW){y_in[IW-1]}}, y_in, {GW{1'b0}}};
          z_d     = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        // fold left half-plane into |angle| <= 90 deg so the rotations converge
        if (x_q[W-1] && !y_q[W-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = QTR;
        end else if (x_q[W-1] && y_q[W-1]) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = -QTR;
        end
        i_d     = '0;
        state_d = S_ROT;
      end
      S_ROT: begin
        if (!y_q[W-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + a_cur;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - a_cur;
        end
        if (i_q == CW'(ITER - 1)) begin
          state_d = S_FIN;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      default: begin
        r_d     = x_q[IW+GW:0];
        t_d     = z_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      r_q     <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      r_q     <= r_d;
      t_q     <= t_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign r    = r_q;
  assign t    = t_q;

endmodule
